sram_write_scheduler: RTL and testbench
=======================================

# sram_write_scheduler

Schedules all write traffic into the shared SRAM port around pipeline foreground reads. It sits beside the SRAM access logic and merges the ADC pixel FIFO stream with a buffered SPI image-upload stream. It applies freeze-frame only at frame boundaries so frozen frames never tear. Writes are issued only in cycles the pipeline leaves the port free, and a starvation guard keeps SPI uploads progressing during live video.

## Interface
- X_RES, 800, visible width; pixels with x ≥ X_RES are discarded
- Y_RES, 600, visible height; pixels with y ≥ Y_RES are discarded
- SPI_FIFO_DEPTH, 16, SPI pixel buffer depth; power of two, ≥ 2
- STARVE_LIMIT, 8, consecutive ADC-won free cycles before SPI is forced through; ≥ 1
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- request_active  in  1  pipeline owns the SRAM port this cycle; no write may issue
- freeze_request  in  1  requested freeze state, sampled at frame start
- frozen  out  1  freeze state currently applied to ADC writes
- adc_pixel_data  in  38  {x[10:0], y[10:0], rgb565[15:0]}, first-word-fall-through ADC FIFO head
- adc_pixel_ready  in  1  ADC FIFO head valid
- adc_pixel_read  out  1  combinational pop of the ADC FIFO head this cycle
- spi_pixel_valid  in  1  SPI pixel offered
- spi_pixel_in  in  16  SPI pixel rgb565
- spi_pixel_x, spi_pixel_y  in  11 each  SPI pixel coordinates
- spi_ready  out  1  SPI FIFO can accept a pixel (level < SPI_FIFO_DEPTH)
- spi_overflow  out  1  sticky: a valid SPI pixel arrived while the FIFO was full
- spi_level  out  clog2(SPI_FIFO_DEPTH)+1  current SPI FIFO occupancy
- wr_valid  out  1  registered write strobe to the SRAM interface
- wr_addr  out  20  {x[9:0], y[9:0]}
- wr_data  out  16  rgb565

## Operation
- **SPI ingress.** A pixel is accepted when spi_pixel_valid & spi_ready. Accepted pixels with x ≥ X_RES or y ≥ Y_RES are dropped and not stored. spi_pixel_valid while full sets spi_overflow and loses the pixel. A push is never accepted while full, even if a pop occurs in the same cycle. Push and pop in the same non-full cycle leaves spi_level unchanged.
- **Free cycle.** A cycle is free when request_active = 0. Nothing is granted or popped in a non-free cycle.
- **Arbitration in a free cycle.**
  - Default grant goes to ADC when adc_pixel_ready = 1, else to SPI when the FIFO is non-empty.
  - starve_cnt increments, saturating at STARVE_LIMIT, in each free cycle where ADC is granted while SPI is non-empty.
  - When starve_cnt = STARVE_LIMIT and SPI is non-empty, SPI is granted instead. starve_cnt is cleared on any SPI grant and whenever the FIFO is empty.
- **ADC grant.**
  - adc_pixel_read = 1 in the same cycle, whether or not a write results.
  - The write issues only if !frozen_eff, x < X_RES and y < Y_RES. Otherwise the pixel is consumed and discarded, and the slot goes unused.
- **Freeze sync.** Frame start is an ADC grant of a pixel with x = 0 and y = 0. At that grant, frozen takes the value of freeze_request. frozen_eff for that pixel is the new value, and every other pixel uses the registered frozen. freeze_request changes mid-frame have no effect until the next frame start.
- **SPI grant.** Pops the FIFO head and issues its write. The frozen state does not affect SPI writes.
- **Address mapping.** wr_addr = {x[9:0], y[9:0]}. The MSBs of the 11-bit coordinates are not stored.

## Timing
- **Reset values.** wr_valid = 0, wr_addr = 0, wr_data = 0, frozen = 0, spi_overflow = 0, spi_level = 0, spi_ready = 1, adc_pixel_read = 0, starve_cnt = 0. Reset asserted mid-operation empties the FIFO and discards its contents. No write is emitted in the cycle after reset release.
- **Write output.** wr_valid/wr_addr/wr_data are registered and asserted exactly one cycle after the granting cycle. wr_valid is high for exactly one cycle per issued write and is 0 otherwise.
- **SPI latency.** Minimum push-to-write latency is 2 cycles: push at edge N, grant in cycle N+1, wr_valid in cycle N+2.
- **Status timing.** spi_level and spi_ready update on the edge following a push or pop. spi_overflow sets on the edge following the dropped pixel.
- **Throughput.** At most one write per free cycle and one ADC pop per free cycle.

## Test plan
- **Read blocking.** request_active = 1 continuously, ADC and SPI both pending -> adc_pixel_read = 0, wr_valid = 0, and spi_level holds.
- **ADC write.** request_active = 0, ADC pixel (x=5, y=7, 0xF800) -> adc_pixel_read same cycle; next cycle wr_valid = 1, wr_addr = {10'd5, 10'd7}, wr_data = 0xF800. A pixel at (800, 0) is popped with no write.
- **Starvation guard.** STARVE_LIMIT = 8, ADC always ready, one SPI pixel queued -> 8 ADC writes, then an SPI write on the 9th free cycle, then ADC resumes. starve_cnt returns to 0.
- **Overflow.** SPI_FIFO_DEPTH = 16, 17 valid pixels with no free cycles -> spi_ready = 0 after the 16th, spi_overflow = 1 after the 17th, spi_level = 16. A following drain writes exactly 16 pixels in order.
- **Freeze sync.** freeze_request = 1 raised mid-frame -> ADC writes continue until pixel (0,0). From pixel (0,0) onward frozen = 1 and ADC writes stop while SPI writes continue. Dropping freeze_request unfreezes at the next (0,0), and that pixel is written.
- **Async reset.** rst_n low mid-stream with 5 SPI pixels queued -> all outputs immediately take their reset values. After release, spi_level = 0 and no stale writes appear.

Source files
------------

// File: rtl/sram_write_scheduler.sv
// Merges the ADC pixel stream and a buffered SPI image upload onto the shared SRAM
// write port, using only cycles the pipeline leaves free; freeze applies at frame start.
module sram_write_scheduler #(
   parameter  int X_RES          = 800,
   parameter  int Y_RES          = 600,
   parameter  int SPI_FIFO_DEPTH = 16,
   parameter  int STARVE_LIMIT   = 8,
   localparam int AW             = $clog2(SPI_FIFO_DEPTH),
   localparam int LW             = AW + 1,
   localparam int SW             = $clog2(STARVE_LIMIT + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          request_active,
   input  logic          freeze_request,
   output logic          frozen,
   input  logic [37:0]   adc_pixel_data,
   input  logic          adc_pixel_ready,
   output logic          adc_pixel_read,
   input  logic          spi_pixel_valid,
   input  logic [15:0]   spi_pixel_in,
   input  logic [10:0]   spi_pixel_x,
   input  logic [10:0]   spi_pixel_y,
   output logic          spi_ready,
   output logic          spi_overflow,
   output logic [LW-1:0] spi_level,
   output logic          wr_valid,
   output logic [19:0]   wr_addr,
   output logic [15:0]   wr_data
);

   localparam logic [10:0]   X_LIM      = 11'(X_RES);
   localparam logic [10:0]   Y_LIM      = 11'(Y_RES);
   localparam logic [LW-1:0] FULL_LVL   = LW'(SPI_FIFO_DEPTH);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic [10:0]   adc_x_s, adc_y_s;
   logic [15:0]   adc_rgb_s;
   logic [35:0]   fifo_mem_q [SPI_FIFO_DEPTH];
   logic [35:0]   fifo_head_s;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          ovf_q, ovf_d, frozen_q, frozen_d;
   logic          wr_valid_q, wr_valid_d;
   logic [19:0]   wr_addr_q, wr_addr_d;
   logic [15:0]   wr_data_q, wr_data_d;
   logic          free_s, spi_ne_s, full_s, grant_spi_s, grant_adc_s;
   logic          frame_start_s, frozen_eff_s, adc_wr_s, spi_in_range_s, push_s;

   assign {adc_x_s, adc_y_s, adc_rgb_s} = adc_pixel_data;

   assign free_s         = !request_active;
   assign spi_ne_s       = (level_q != {LW{1'b0}});
   assign full_s         = (level_q == FULL_LVL);
   assign grant_spi_s    = free_s && spi_ne_s && (!adc_pixel_ready || (starve_q == STARVE_MAX));
   assign grant_adc_s    = free_s && adc_pixel_ready && !grant_spi_s;
   assign frame_start_s  = grant_adc_s && (adc_x_s == 11'd0) && (adc_y_s == 11'd0);
   assign frozen_eff_s   = frame_start_s ? freeze_request : frozen_q;
   assign adc_wr_s       = grant_adc_s && !frozen_eff_s && (adc_x_s < X_LIM) && (adc_y_s < Y_LIM);
   assign spi_in_range_s = (spi_pixel_x < X_LIM) && (spi_pixel_y < Y_LIM);
   assign push_s         = spi_pixel_valid && !full_s && spi_in_range_s;
   assign fifo_head_s    = fifo_mem_q[rd_ptr_q];

   // The pop strobe is combinational, so it is also masked while reset is held.
   assign adc_pixel_read = grant_adc_s && rst_n;
   assign spi_ready      = !full_s;
   assign spi_overflow   = ovf_q;
   assign spi_level      = level_q;
   assign frozen         = frozen_q;
   assign wr_valid       = wr_valid_q;
   assign wr_addr        = wr_addr_q;
   assign wr_data        = wr_data_q;

   // Next-state for FIFO bookkeeping, starvation counter, freeze and write port.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      starve_d   = starve_q;
      ovf_d      = ovf_q;
      frozen_d   = frozen_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (grant_spi_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, grant_spi_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      if (spi_pixel_valid && full_s) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end

      if (!spi_ne_s || grant_spi_s) begin
         starve_d = {SW{1'b0}};
      end else if (grant_adc_s && (starve_q != STARVE_MAX)) begin
         starve_d = starve_q + SW'(1);
      end else begin
         starve_d = starve_q;
      end

      if (frame_start_s) begin
         frozen_d = freeze_request;
      end else begin
         frozen_d = frozen_q;
      end

      if (grant_spi_s) begin
         wr_valid_d = 1'b1;
         wr_addr_d  = fifo_head_s[35:16];
         wr_data_d  = fifo_head_s[15:0];
      end else if (adc_wr_s) begin
         wr_valid_d = 1'b1;
         wr_addr_d  = {adc_x_s[9:0], adc_y_s[9:0]};
         wr_data_d  = adc_rgb_s;
      end else begin
         wr_valid_d = 1'b0;
      end
   end

   // State registers; reset empties the FIFO by clearing its pointers and level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= {AW{1'b0}};
         rd_ptr_q   <= {AW{1'b0}};
         level_q    <= {LW{1'b0}};
         starve_q   <= {SW{1'b0}};
         ovf_q      <= 1'b0;
         frozen_q   <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= 20'd0;
         wr_data_q  <= 16'd0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         starve_q   <= starve_d;
         ovf_q      <= ovf_d;
         frozen_q   <= frozen_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   // FIFO storage holds only the stored address bits and colour.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem_q[wr_ptr_q] <= {spi_pixel_x[9:0], spi_pixel_y[9:0], spi_pixel_in};
      end
   end

endmodule

// File: tb/tb_sram_write_scheduler.sv
// Bench for sram_write_scheduler: directed scenarios plus random traffic against a
// queue-based reference model of the scheduling rules.
module tb_sram_write_scheduler;

   localparam int X_RES = 800;
   localparam int Y_RES = 600;
   localparam int DEPTH = 16;
   localparam int LIMIT = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        request_active, freeze_request, frozen;
   logic [10:0] ax, ay, sx, sy;
   logic [15:0] argb, srgb;
   logic [37:0] adc_pixel_data;
   logic        adc_pixel_ready, adc_pixel_read;
   logic        spi_pixel_valid, spi_ready, spi_overflow;
   logic [4:0]  spi_level;
   logic        wr_valid;
   logic [19:0] wr_addr;
   logic [15:0] wr_data;

   assign adc_pixel_data = {ax, ay, argb};

   sram_write_scheduler #(
      .X_RES(X_RES), .Y_RES(Y_RES), .SPI_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .request_active(request_active),
      .freeze_request(freeze_request), .frozen(frozen),
      .adc_pixel_data(adc_pixel_data), .adc_pixel_ready(adc_pixel_ready),
      .adc_pixel_read(adc_pixel_read), .spi_pixel_valid(spi_pixel_valid),
      .spi_pixel_in(srgb), .spi_pixel_x(sx), .spi_pixel_y(sy),
      .spi_ready(spi_ready), .spi_overflow(spi_overflow), .spi_level(spi_level),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [35:0] m_q[$];
   int          m_starve;
   bit          m_frozen, m_ovf, m_wv;
   logic [19:0] m_wa;
   logic [15:0] m_wd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      m_q.delete();
      m_starve = 0;
      m_frozen = 1'b0;
      m_ovf    = 1'b0;
      m_wv     = 1'b0;
      m_wa     = 20'd0;
      m_wd     = 16'd0;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
      chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
      chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
      chk({tag, "_frozen"}, 32'(frozen), 32'd0);
      chk({tag, "_overflow"}, 32'(spi_overflow), 32'd0);
      chk({tag, "_level"}, 32'(spi_level), 32'd0);
      chk({tag, "_ready"}, 32'(spi_ready), 32'd1);
      chk({tag, "_adc_read"}, 32'(adc_pixel_read), 32'd0);
   endtask

   task automatic set_adc(input logic rdy, input int x, input int y, input logic [15:0] c);
      adc_pixel_ready = rdy;
      ax = 11'(x);
      ay = 11'(y);
      argb = c;
   endtask

   task automatic set_spi(input logic vld, input int x, input int y, input logic [15:0] c);
      spi_pixel_valid = vld;
      sx = 11'(x);
      sy = 11'(y);
      srgb = c;
   endtask

   // One clock cycle: called just after a falling edge with inputs already driven.
   task automatic step();
      int          sz;
      bit          full_pre, has, g_spi, g_adc, fs, eff, wrote;
      logic [35:0] w;
      logic [19:0] na;
      logic [15:0] nd;
      #2;
      sz = m_q.size();
      full_pre = (sz == DEPTH);
      has = (sz != 0);
      g_spi = 1'b0;
      g_adc = 1'b0;
      wrote = 1'b0;
      na = 20'd0;
      nd = 16'd0;
      if (!request_active) begin
         if (has && (!adc_pixel_ready || m_starve == LIMIT)) g_spi = 1'b1;
         else if (adc_pixel_ready) g_adc = 1'b1;
      end
      fs  = g_adc && ax == 11'd0 && ay == 11'd0;
      eff = fs ? freeze_request : m_frozen;

      chk("adc_pixel_read", 32'(adc_pixel_read), 32'(g_adc));
      chk("spi_level", 32'(spi_level), 32'(sz));
      chk("spi_ready", 32'(spi_ready), 32'(!full_pre));
      chk("spi_overflow", 32'(spi_overflow), 32'(m_ovf));
      chk("frozen", 32'(frozen), 32'(m_frozen));
      chk("wr_valid", 32'(wr_valid), 32'(m_wv));
      if (m_wv) begin
         chk("wr_addr", 32'(wr_addr), 32'(m_wa));
         chk("wr_data", 32'(wr_data), 32'(m_wd));
      end

      if (g_spi) begin
         w = m_q.pop_front();
         wrote = 1'b1;
         na = w[35:16];
         nd = w[15:0];
         m_starve = 0;
      end else if (g_adc) begin
         if (fs) m_frozen = freeze_request;
         if (!eff && int'(ax) < X_RES && int'(ay) < Y_RES) begin
            wrote = 1'b1;
            na = {ax[9:0], ay[9:0]};
            nd = argb;
         end
         if (has) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      end
      if (!has) m_starve = 0;
      if (spi_pixel_valid) begin
         if (full_pre) m_ovf = 1'b1;
         else if (int'(sx) < X_RES && int'(sy) < Y_RES) m_q.push_back({sx[9:0], sy[9:0], srgb});
      end
      m_wv = wrote;
      if (wrote) begin
         m_wa = na;
         m_wd = nd;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic int rand_coord(input int lim);
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2) return 0;
      if (r == 2) return lim + int'($urandom_range(0, 2047 - lim));
      return int'($urandom_range(0, lim - 1));
   endfunction

   initial begin
      rst_n = 1'b0;
      request_active = 1'b0;
      freeze_request = 1'b0;
      set_adc(1'b1, 5, 7, 16'hF800);
      set_spi(1'b0, 0, 0, 16'h0000);
      reset_model();
      #3;
      chk_reset_values("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // read blocking: port busy, both sources pending
      request_active = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_spi(1'b1, 100 + i, 50, 16'h1000 + 16'(i));
         step();
      end
      set_spi(1'b0, 0, 0, 16'h0000);
      for (int i = 0; i < 3; i++) step();
      chk("block_level_held", 32'(spi_level), 32'd3);

      // ADC write, then an out-of-range pixel that is consumed silently
      request_active = 1'b0;
      set_adc(1'b1, 5, 7, 16'hF800);
      step();
      chk("adc_write_addr", 32'(wr_addr), 32'({10'd5, 10'd7}));
      chk("adc_write_data", 32'(wr_data), 32'h0000F800);
      set_adc(1'b1, 800, 0, 16'h07E0);
      step();
      chk("adc_oob_no_write", 32'(wr_valid), 32'd0);
      set_adc(1'b0, 0, 0, 16'h0000);
      for (int i = 0; i < 5; i++) step();

      // starvation guard: one SPI pixel against a continuously ready ADC
      for (int i = 0; i < 12; i++) begin
         set_adc(1'b1, 10 + i, 20, 16'h0100 + 16'(i));
         if (i == 0) set_spi(1'b1, 33, 44, 16'hABCD);
         else set_spi(1'b0, 0, 0, 16'h0000);
         step();
         if (i == 9) chk("starve_spi_write", 32'(wr_data), 32'h0000ABCD);
      end

      // overflow with no free cycles, then drain in order
      request_active = 1'b1;
      set_adc(1'b0, 0, 0, 16'h0000);
      for (int i = 0; i < 17; i++) begin
         set_spi(1'b1, i, i + 1, 16'h2000 + 16'(i));
         step();
      end
      set_spi(1'b0, 0, 0, 16'h0000);
      chk("ovf_level", 32'(spi_level), 32'd16);
      chk("ovf_ready", 32'(spi_ready), 32'd0);
      chk("ovf_sticky", 32'(spi_overflow), 32'd1);
      request_active = 1'b0;
      for (int i = 0; i < 18; i++) step();

      // freeze applied only at frame start, SPI unaffected
      freeze_request = 1'b1;
      set_adc(1'b1, 3, 4, 16'h3333); step();
      set_adc(1'b1, 5, 4, 16'h3334); step();
      set_adc(1'b1, 0, 0, 16'h3335); step();
      chk("freeze_applied", 32'(frozen), 32'd1);
      set_adc(1'b1, 1, 0, 16'h3336);
      set_spi(1'b1, 9, 9, 16'h4444); step();
      set_spi(1'b0, 0, 0, 16'h0000);
      freeze_request = 1'b0;
      set_adc(1'b0, 0, 0, 16'h0000); step();
      set_adc(1'b1, 2, 0, 16'h3337); step();
      set_adc(1'b1, 0, 0, 16'h3338); step();
      chk("unfreeze_write", 32'(wr_data), 32'h00003338);
      set_adc(1'b1, 1, 0, 16'h3339); step();

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         request_active = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 99) == 0) freeze_request = ~freeze_request;
         set_adc(1'($urandom_range(0, 9) < 7), rand_coord(X_RES), rand_coord(Y_RES), 16'($urandom));
         set_spi(1'($urandom_range(0, 1)), rand_coord(X_RES), rand_coord(Y_RES), 16'($urandom));
         step();
      end

      // async reset mid-stream with five SPI pixels queued
      set_adc(1'b0, 0, 0, 16'h0000);
      request_active = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_spi(1'b1, 200 + i, 300, 16'h5000 + 16'(i));
         step();
      end
      chk("pre_reset_level", 32'(spi_level), 32'(m_q.size()));
      set_spi(1'b0, 0, 0, 16'h0000);
      request_active = 1'b0;
      set_adc(1'b1, 6, 6, 16'h6666);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_values("async_reset");
      reset_model();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      set_adc(1'b0, 0, 0, 16'h0000);
      for (int i = 0; i < 4; i++) step();
      for (int i = 0; i < 200; i++) begin
         request_active = ($urandom_range(0, 2) == 0);
         set_adc(1'($urandom_range(0, 1)), rand_coord(X_RES), rand_coord(Y_RES), 16'($urandom));
         set_spi(1'($urandom_range(0, 1)), rand_coord(X_RES), rand_coord(Y_RES), 16'($urandom));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
